gain_apply_ramp: RTL and testbench
==================================

GAIN_APPLY_RAMP -- requirements
Module: gain_apply_ramp

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width in bits (signed).
REQ-002 SHALL have parameter NUM_GAIN_STEP, default 3; the gain word is NUM_GAIN_STEP+1 bits signed.
REQ-003 SHALL have port i_clk, input, 1, the only clock; all logic is rising-edge triggered.
REQ-004 SHALL have port i_rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port i_gain, input, NUM_GAIN_STEP+1, signed target gain from the amplitude controller; may change on any cycle.
REQ-006 SHALL have port i_sample, input, DATA_W, signed wave/noise sample.
REQ-007 SHALL have port i_valid, input, 1, i_sample is valid.
REQ-008 SHALL have port o_ready, output, 1, the block accepts i_sample this cycle.
REQ-009 SHALL have port o_sample, output, DATA_W, signed scaled sample.
REQ-010 SHALL have port o_valid, output, 1, o_sample is valid.
REQ-011 SHALL have port i_ready, input, 1, downstream accepts o_sample.
REQ-012 SHALL have port o_clip, output, 1, the current o_sample was saturated (qualified by o_valid).
REQ-013 SHALL have port o_gain_active, output, NUM_GAIN_STEP+1, signed gain currently applied.

Function
REQ-014 SHALL transfer an input when i_valid & o_ready, and an output when o_valid & i_ready.
REQ-015 SHALL drive o_ready = i_ready | ~o_valid (global advance); all pipeline stages hold when o_ready=0.
REQ-016 SHALL use a 2-stage pipeline: stage 1 registers the full-precision product i_sample*gain_active (DATA_W+NUM_GAIN_STEP+1 bits signed); stage 2 registers the saturated result and o_clip.
REQ-017 SHALL have a latency of exactly 2 cycles from input transfer to o_valid with no stall; bubbles propagate as o_valid=0.
REQ-018 SHALL saturate results above 2^(DATA_W-1)-1 to that value and results below -2^(DATA_W-1) to -2^(DATA_W-1), with o_clip=1 for that sample; otherwise o_clip=0 and o_sample equals the product exactly.
REQ-019 SHALL implement a ramp FSM with states TRACK (gain_active==i_gain), RAMP_UP (gain_active<i_gain) and RAMP_DOWN (gain_active>i_gain).
REQ-020 SHALL step gain_active by +1 in RAMP_UP and by -1 in RAMP_DOWN only on an input-transfer cycle; the sample transferred on that cycle uses the pre-step value.
REQ-021 SHALL evaluate the FSM state each cycle from gain_active versus the current i_gain; a target change mid-ramp retargets immediately, including reversing direction.
REQ-022 SHALL never step gain_active past i_gain, and SHALL never wrap it outside the signed range.
REQ-023 SHALL output o_sample=0, o_clip=0 for gain 0 (mute); a negative gain inverts polarity (e.g. -2^(DATA_W-1) * -1 saturates to the maximum positive value with o_clip=1).
REQ-024 SHALL hold gain_active unchanged while no input transfers occur (stall or i_valid=0).

Reset
REQ-025 SHALL, while i_rst=1 at a clock edge, set gain_active=1, FSM=TRACK if i_gain==1 else re-evaluate on the next cycle, both pipeline valid bits=0, o_sample=0, o_clip=0.
REQ-026 SHALL discard in-flight samples on reset mid-operation; o_valid=0 in the cycle after reset is sampled.
REQ-027 SHALL keep o_ready=1 during and after reset (o_valid=0).

Structure
REQ-028 SHALL place DATA_W and NUM_GAIN_STEP defaults, GAIN_RESET=1 and the ramp state enum (TRACK, RAMP_UP, RAMP_DOWN) in shared package amp_pkg.
REQ-029 SHALL implement the ramp FSM and the gain_active register as sub-module gain_ramp (inputs i_clk, i_rst, i_gain, i_step_en; output o_gain_active).

Verification
REQ-030 Reset, i_gain=1, sample 1000 with i_ready=1 -> o_sample=1000 two cycles later, o_clip=0.
REQ-031 i_gain changes 1->5, continuous valid samples 100 -> outputs 100,200,300,400,500,500..., o_gain_active reaches 5 after 4 transfers.
REQ-032 gain_active=7, sample 8000, DATA_W=16 -> o_sample=32767, o_clip=1; sample -8000 -> -32768, o_clip=1.
REQ-033 i_ready=0 for 5 cycles with o_valid=1 -> o_ready=0, o_sample stable, gain_active unchanged; release -> sample order preserved, no loss or duplication.
REQ-034 Ramping 1->6, change i_gain to 2 at gain_active=4 -> next steps 3, 2, then TRACK.
REQ-035 i_rst asserted with two samples in flight -> no o_valid afterwards for them, gain_active=1.

Source files
------------

// File: rtl/amp_pkg.sv
// Shared amplitude-path types and defaults.
// Used by the gain ramp and the gain apply pipeline.
package amp_pkg;

   localparam int DATA_W_DEF        = 16;
   localparam int NUM_GAIN_STEP_DEF = 3;
   localparam int GAIN_RESET        = 1;

   typedef enum logic [1:0] {
      TRACK,
      RAMP_UP,
      RAMP_DOWN
   } ramp_state_e;

endpackage

// File: rtl/gain_ramp.sv
// Slews the applied gain one step per accepted sample
// toward the requested target gain.
module gain_ramp
   import amp_pkg::*;
#(
   parameter int GW = NUM_GAIN_STEP_DEF + 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [GW-1:0] i_gain,
   input  logic          i_step_en,
   output logic [GW-1:0] o_gain_active
);

   logic [GW-1:0] gain_q;
   logic [GW-1:0] gain_d;
   ramp_state_e   state;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         gain_q <= GW'(GAIN_RESET);
      end else begin
         gain_q <= gain_d;
      end
   end

   // State follows the live target, so a retarget takes effect at once.
   always_comb begin
      state  = TRACK;
      gain_d = gain_q;
      unique case (1'b1)
         ($signed(gain_q) < $signed(i_gain)): state = RAMP_UP;
         ($signed(gain_q) > $signed(i_gain)): state = RAMP_DOWN;
         default:                             state = TRACK;
      endcase
      if (i_step_en) begin
         unique case (state)
            RAMP_UP:   gain_d = gain_q + GW'(1);
            RAMP_DOWN: gain_d = gain_q - GW'(1);
            default:   gain_d = gain_q;
         endcase
      end
   end

   assign o_gain_active = gain_q;

endmodule

// File: rtl/gain_apply_ramp.sv
// Two-stage gain multiply with saturation; the applied gain
// ramps toward the target one step per accepted sample.
module gain_apply_ramp
   import amp_pkg::*;
#(
   parameter int DATA_W        = DATA_W_DEF,
   parameter int NUM_GAIN_STEP = NUM_GAIN_STEP_DEF
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [NUM_GAIN_STEP:0] i_gain,
   input  logic [DATA_W-1:0]      i_sample,
   input  logic                   i_valid,
   output logic                   o_ready,
   output logic [DATA_W-1:0]      o_sample,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic                   o_clip,
   output logic [NUM_GAIN_STEP:0] o_gain_active
);

   localparam int GW = NUM_GAIN_STEP + 1;
   localparam int PW = DATA_W + GW;

   logic                     adv;
   logic                     xfer;
   logic [GW-1:0]            gain_active;
   logic signed [DATA_W-1:0] smp_s;
   logic signed [GW-1:0]     gain_s;
   logic signed [PW-1:0]     prod_d;
   logic signed [PW-1:0]     prod_q;
   logic                     v1_q;
   logic                     v2_q;
   logic                     ovf;
   logic [DATA_W-1:0]        sat_d;

   assign adv  = i_ready | ~v2_q;
   assign xfer = i_valid & adv;

   gain_ramp #(
      .GW(GW)
   ) u_ramp (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_gain       (i_gain),
      .i_step_en    (xfer),
      .o_gain_active(gain_active)
   );

   assign smp_s  = i_sample;
   assign gain_s = gain_active;
   assign prod_d = smp_s * gain_s;

   // Fits in DATA_W only if all bits from the output sign bit up agree.
   always_comb begin
      ovf   = ~((&prod_q[PW-1:DATA_W-1]) | ~(|prod_q[PW-1:DATA_W-1]));
      sat_d = prod_q[DATA_W-1:0];
      if (ovf) begin
         sat_d = prod_q[PW-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                              : {1'b0, {(DATA_W-1){1'b1}}};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         prod_q   <= '0;
         o_sample <= '0;
         o_clip   <= 1'b0;
      end else if (adv) begin
         v1_q     <= i_valid;
         prod_q   <= prod_d;
         v2_q     <= v1_q;
         o_sample <= sat_d;
         o_clip   <= v1_q & ovf;
      end
   end

   assign o_ready       = adv;
   assign o_valid       = v2_q;
   assign o_gain_active = gain_active;

endmodule

// File: tb/tb_gain_apply_ramp.sv
// Directed bench for gain_apply_ramp: expected outputs are
// queued at input transfer and checked by an output monitor.
module tb_gain_apply_ramp;

   logic               clk = 1'b0;
   logic               i_rst;
   logic signed [3:0]  i_gain;
   logic signed [15:0] i_sample;
   logic               i_valid;
   logic               o_ready;
   logic signed [15:0] o_sample;
   logic               o_valid;
   logic               i_ready;
   logic               o_clip;
   logic signed [3:0]  o_gain_active;

   typedef struct {
      logic signed [15:0] s;
      logic               c;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   gain_apply_ramp #(
      .DATA_W       (16),
      .NUM_GAIN_STEP(3)
   ) dut (
      .i_clk        (clk),
      .i_rst        (i_rst),
      .i_gain       (i_gain),
      .i_sample     (i_sample),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .o_sample     (o_sample),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_clip       (o_clip),
      .o_gain_active(o_gain_active)
   );

   always @(negedge clk) begin
      if (!i_rst && o_valid && i_ready) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL out_spurious got=%0d want=none", o_sample);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (o_sample !== e.s || o_clip !== e.c) begin
               bad++;
               $display("FAIL out_data got=%0d/%0b want=%0d/%0b",
                        o_sample, o_clip, e.s, e.c);
            end
         end
      end
   end

   task automatic chk(input string n, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", n, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 after the transfer edge.
   task automatic send(input logic signed [15:0] s,
                       input logic signed [15:0] e,
                       input logic c);
      bit   ok;
      exp_t x;
      ok       = 1'b0;
      i_sample = s;
      i_valid  = 1'b1;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         if (o_ready) begin
            x.s = e;
            x.c = c;
            sb.push_back(x);
            ok  = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL send_timeout got=blocked want=accepted");
      end
   endtask

   task automatic idle();
      i_valid  = 1'b0;
      i_sample = '0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (sb.size() != 0 && k < 100) begin
         tick(1);
         k++;
      end
      chk("drain_left", sb.size(), 0);
   endtask

   initial begin
      i_rst    = 1'b1;
      i_gain   = 4'sd1;
      i_sample = '0;
      i_valid  = 1'b0;
      i_ready  = 1'b1;
      tick(3);
      chk("rst_valid", int'(o_valid), 0);
      chk("rst_ready", int'(o_ready), 1);
      chk("rst_sample", int'(o_sample), 0);
      chk("rst_clip", int'(o_clip), 0);
      chk("rst_gain", int'(o_gain_active), 1);
      i_rst = 1'b0;
      tick(1);
      chk("post_rst_ready", int'(o_ready), 1);

      // Unity gain pass-through
      send(16'sd1000, 16'sd1000, 1'b0);
      idle();
      drain();

      // Ramp 1 -> 5
      i_gain = 4'sd5;
      send(16'sd100, 16'sd100, 1'b0);
      send(16'sd100, 16'sd200, 1'b0);
      send(16'sd100, 16'sd300, 1'b0);
      send(16'sd100, 16'sd400, 1'b0);
      chk("gain_5", int'(o_gain_active), 5);
      send(16'sd100, 16'sd500, 1'b0);
      send(16'sd100, 16'sd500, 1'b0);
      idle();
      drain();

      // Saturation at gain 7
      i_gain = 4'sd7;
      send(16'sd0, 16'sd0, 1'b0);
      send(16'sd0, 16'sd0, 1'b0);
      chk("gain_7", int'(o_gain_active), 7);
      send(16'sd8000, 16'sd32767, 1'b1);
      send(-16'sd8000, -16'sd32768, 1'b1);
      send(16'sd4681, 16'sd32767, 1'b0);
      send(16'sd4682, 16'sd32767, 1'b1);
      idle();
      drain();

      // Ramp down to mute
      i_gain = 4'sd0;
      for (int g = 7; g >= 1; g--) begin
         send(16'sd1, 16'(g), 1'b0);
      end
      send(16'sd1234, 16'sd0, 1'b0);
      chk("gain_0", int'(o_gain_active), 0);

      // Polarity inversion
      i_gain = -4'sd1;
      send(16'sd5, 16'sd0, 1'b0);
      send(-16'sd32768, 16'sd32767, 1'b1);
      send(16'sd300, -16'sd300, 1'b0);
      idle();
      drain();
      chk("gain_m1", int'(o_gain_active), -1);

      // Backpressure
      i_ready = 1'b0;
      send(16'sd10, -16'sd10, 1'b0);
      send(16'sd20, -16'sd20, 1'b0);
      idle();
      i_gain = 4'sd3;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_ready", int'(o_ready), 0);
         chk("stall_sample", int'(o_sample), -10);
         chk("stall_gain", int'(o_gain_active), -1);
         @(posedge clk);
         #1;
      end
      i_gain  = -4'sd1;
      i_ready = 1'b1;
      drain();

      // Retarget mid-ramp
      i_gain = 4'sd1;
      send(16'sd0, 16'sd0, 1'b0);
      send(16'sd0, 16'sd0, 1'b0);
      chk("gain_1", int'(o_gain_active), 1);
      i_gain = 4'sd6;
      send(16'sd100, 16'sd100, 1'b0);
      send(16'sd100, 16'sd200, 1'b0);
      send(16'sd100, 16'sd300, 1'b0);
      chk("gain_4", int'(o_gain_active), 4);
      i_gain = 4'sd2;
      send(16'sd100, 16'sd400, 1'b0);
      chk("gain_3", int'(o_gain_active), 3);
      send(16'sd100, 16'sd300, 1'b0);
      send(16'sd100, 16'sd200, 1'b0);
      send(16'sd100, 16'sd200, 1'b0);
      chk("gain_2", int'(o_gain_active), 2);
      idle();
      drain();

      // Reset with two samples in flight
      i_ready = 1'b0;
      send(16'sd7, 16'sd14, 1'b0);
      send(16'sd9, 16'sd18, 1'b0);
      idle();
      i_rst = 1'b1;
      tick(1);
      sb.delete();
      chk("mid_rst_valid", int'(o_valid), 0);
      chk("mid_rst_ready", int'(o_ready), 1);
      chk("mid_rst_gain", int'(o_gain_active), 1);
      i_rst   = 1'b0;
      i_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("flush_valid", int'(o_valid), 0);
         @(posedge clk);
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
